i2c_target_regfile: RTL and testbench

Parameterised I2C target (slave) with an internal byte-wide register file. It is the successor to the fixed 32-register, fixed-address datapath. The block adds a programmable target address, configurable register count, a register-pointer protocol with auto-increment and wrap, repeated-START support and a write-notification strobe. It sits between the synchronised I2C pins and the system logic, which consumes the register file as a packed vector.

---
 rtl/i2c_target_regfile_if.sv | 9 +
 rtl/i2c_target_regfile.sv | 189 ++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regfile_if.sv
// I2C pin bundle between a bus master (or pad logic) and the register-file target.
interface i2c_target_regfile_if;
  logic SCL;
  logic SDA_in;
  logic SDA_out;

  modport master (output SCL, output SDA_in, input SDA_out);
  modport slave  (input SCL, input SDA_in, output SDA_out);
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, pointer auto-increment and repeated START.
// Optional: define I2C_RO_ID_EN to make register 0 a read-only ID_VALUE.
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'h20,
  parameter int         NUM_REGS    = 32,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  localparam int        PTR_W       = $clog2(NUM_REGS)
) (
  input  logic                    clock,
  input  logic                    reset,
  i2c_target_regfile_if.slave     bus,
  output logic [8*NUM_REGS-1:0]   regs_packed,
  output logic                    wr_strobe,
  output logic [PTR_W-1:0]        wr_index,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, ADDR, PTR, WRITE, READ, READ_ACK} state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;

  // sda_prev_q is the SDA level aligned with the registered SCL edge pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.SCL};
      sda_sync_q <= {sda_sync_q[0], bus.SDA_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      scl_rise_q <=  scl_sync_q[1] & ~scl_prev_q;
      scl_fall_q <= ~scl_sync_q[1] &  scl_prev_q;
      start_q    <=  scl_sync_q[1] &  scl_prev_q & ~sda_sync_q[1] &  sda_prev_q;
      stop_q     <=  scl_sync_q[1] &  scl_prev_q &  sda_sync_q[1] & ~sda_prev_q;
    end
  end

  state_e           state_q;
  logic [7:0]       regs_q    [NUM_REGS];
  logic [7:0]       regs_view [NUM_REGS];
  logic [7:0]       shift_q;
  logic [3:0]       cnt_q;
  logic             ack_q, mack_q;
  logic [PTR_W-1:0] ptr_q, widx_q;
  logic             sda_q, busy_q, strb_q;

  always_comb begin
    for (int j = 0; j < NUM_REGS; j++) regs_view[j] = regs_q[j];
`ifdef I2C_RO_ID_EN
    regs_view[0] = ID_VALUE;
`endif
  end

  for (genvar j = 0; j < NUM_REGS; j++) begin : g_pack
    assign regs_packed[8*j +: 8] = regs_view[j];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REGS-1)) ? '0 : p + 1'b1;
  endfunction

  // In receive states cnt_q counts sampled bits; ack_q marks the ACK slot after bit 8.
  // In READ cnt_q counts driven bits; bit 7 goes out on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int j = 0; j < NUM_REGS; j++) regs_q[j] <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      mack_q  <= 1'b0;
      ptr_q   <= '0;
      widx_q  <= '0;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      strb_q <= 1'b0;
      if (stop_q) begin
        state_q <= IDLE;
        sda_q   <= 1'b1;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
        ack_q   <= 1'b0;
        mack_q  <= 1'b0;
      end else if (start_q) begin
        state_q <= ADDR;
        sda_q   <= 1'b1;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        ack_q   <= 1'b0;
        mack_q  <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WRITE: begin
            if (scl_rise_q && cnt_q != 4'd8) begin
              shift_q <= {shift_q[6:0], sda_prev_q};
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall_q && cnt_q == 4'd8) begin
              if (!ack_q) begin
                ack_q <= 1'b1;
                case (state_q)
                  ADDR:
                    if (shift_q[7:1] == TARGET_ADDR) sda_q <= 1'b0;
                    else state_q <= IDLE;
                  PTR:
                    if ({1'b0, shift_q} < 9'(NUM_REGS)) begin
                      ptr_q <= shift_q[PTR_W-1:0];
                      sda_q <= 1'b0;
                    end else state_q <= IDLE;
                  default: begin
`ifdef I2C_RO_ID_EN
                    if (ptr_q != '0) begin
                      regs_q[ptr_q] <= shift_q;
                      strb_q        <= 1'b1;
                      widx_q        <= ptr_q;
                    end
`else
                    regs_q[ptr_q] <= shift_q;
                    strb_q        <= 1'b1;
                    widx_q        <= ptr_q;
`endif
                    ptr_q <= ptr_inc(ptr_q);
                    sda_q <= 1'b0;
                  end
                endcase
              end else begin
                ack_q <= 1'b0;
                cnt_q <= '0;
                sda_q <= 1'b1;
                if (state_q == ADDR && shift_q[0]) begin
                  state_q <= READ;
                  shift_q <= regs_view[ptr_q];
                  sda_q   <= regs_view[ptr_q][7];
                  cnt_q   <= 4'd1;
                end else begin
                  state_q <= (state_q == ADDR) ? PTR : WRITE;
                end
              end
            end
          end
          READ: begin
            if (scl_fall_q) begin
              if (cnt_q == 4'd8) begin
                sda_q   <= 1'b1;
                cnt_q   <= '0;
                state_q <= READ_ACK;
              end else begin
                shift_q <= {shift_q[6:0], 1'b0};
                sda_q   <= shift_q[6];
                cnt_q   <= cnt_q + 4'd1;
              end
            end
          end
          READ_ACK: begin
            if (scl_rise_q) begin
              if (!sda_prev_q) begin
                mack_q <= 1'b1;
                ptr_q  <= ptr_inc(ptr_q);
              end else state_q <= IDLE;
            end else if (scl_fall_q && mack_q) begin
              mack_q  <= 1'b0;
              state_q <= READ;
              shift_q <= regs_view[ptr_q];
              sda_q   <= regs_view[ptr_q][7];
              cnt_q   <= 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.SDA_out = sda_q;
  assign wr_strobe   = strb_q;
  assign wr_index    = widx_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Randomised bus-master bench for i2c_target_regfile with a register-array reference model
// and a queue-based scoreboard for bus responses and write strobes.
`timescale 1ns/1ps
module tb_i2c_target_regfile;
  localparam int         NUM_REGS = 32;
  localparam int         PTR_W    = $clog2(NUM_REGS);
  localparam logic [6:0] ADDR     = 7'h20;
  localparam logic [7:0] IDV      = 8'hA5;
  localparam int         Q        = 4;

  typedef logic [7:0] bq_t [$];
  typedef struct { int val; int kind; } exp_t;

  logic clock = 1'b0, reset = 1'b1;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic [8*NUM_REGS-1:0] regs_packed;
  logic wr_strobe, busy;
  logic [PTR_W-1:0] wr_index;

  i2c_target_regfile_if bus();
  assign bus.SCL    = scl_m;
  assign bus.SDA_in = sda_m & bus.SDA_out;

  i2c_target_regfile #(.TARGET_ADDR(ADDR), .NUM_REGS(NUM_REGS), .ID_VALUE(IDV)) dut (
    .clock(clock), .reset(reset), .bus(bus), .regs_packed(regs_packed),
    .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy));

  always #5 clock = ~clock;

  logic [7:0] mdl [NUM_REGS];
  int   mdl_ptr = 0;
  exp_t exp_bus[$];
  int   obs_bus[$];
  int   exp_wr_idx[$], exp_wr_val[$];
  int   errors = 0, checks = 0;
  bit   expect_quiet = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic bit is_ro(input int p);
`ifdef I2C_RO_ID_EN
    return p == 0;
`else
    return (p < 0);
`endif
  endfunction

  function automatic logic [7:0] mdl_rd(input int p);
    return is_ro(p) ? IDV : mdl[p];
  endfunction

  function automatic int inc(input int p);
    return (p + 1) % NUM_REGS;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; clks(Q); scl_m = 1'b1; clks(2*Q); scl_m = 1'b0; clks(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; clks(Q); scl_m = 1'b1; clks(Q); b = bus.SDA_in; clks(Q); scl_m = 1'b0; clks(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; clks(Q); scl_m = 1'b1; clks(Q); sda_m = 1'b0; clks(Q); scl_m = 1'b0; clks(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; clks(Q); scl_m = 1'b1; clks(Q); sda_m = 1'b1; clks(Q + 2);
  endtask

  // ack_lvl is the bus level expected in the ACK slot: 0 = ACK, 1 = NACK/silent
  task automatic send_byte(input logic [7:0] b, input logic ack_lvl);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    exp_bus.push_back('{val: int'(ack_lvl), kind: 0});
    get_bit(a);
    obs_bus.push_back(int'(a));
  endtask

  task automatic recv_byte(input logic [7:0] exp_b, input logic mack);
    logic [7:0] b;
    logic x;
    b = '0;
    exp_bus.push_back('{val: int'(exp_b), kind: 1});
    for (int i = 7; i >= 0; i--) begin get_bit(x); b[i] = x; end
    obs_bus.push_back(int'(b));
    put_bit(mack);
  endtask

  task automatic xfer_write(input logic [6:0] a, input logic [7:0] ptr, input bq_t data);
    bit live;
    live = (a == ADDR);
    bus_start();
    expect_quiet = !live;
    send_byte({a, 1'b0}, !live);
    live = live && (ptr < NUM_REGS);
    send_byte(ptr, !live);
    if (live) mdl_ptr = ptr;
    foreach (data[i]) begin
      if (live) begin
        if (!is_ro(mdl_ptr)) begin
          mdl[mdl_ptr] = data[i];
          exp_wr_idx.push_back(mdl_ptr);
          exp_wr_val.push_back(int'(data[i]));
        end
        mdl_ptr = inc(mdl_ptr);
      end
      send_byte(data[i], !live);
    end
    bus_stop();
    expect_quiet = 1'b0;
    chk("busy_after_write_stop", busy, 0);
  endtask

  task automatic xfer_read(input logic [6:0] a, input int n, input bit set_ptr, input logic [7:0] ptr);
    bit live;
    live = (a == ADDR);
    if (set_ptr) begin
      bus_start();
      send_byte({ADDR, 1'b0}, 1'b0);
      send_byte(ptr, !(ptr < NUM_REGS));
      if (ptr < NUM_REGS) mdl_ptr = ptr;
    end
    bus_start();
    expect_quiet = !live;
    send_byte({a, 1'b1}, !live);
    for (int i = 0; i < n; i++) begin
      recv_byte(live ? mdl_rd(mdl_ptr) : 8'hFF, i == n - 1);
      if (live && i != n - 1) mdl_ptr = inc(mdl_ptr);
    end
    clks(2);
    chk("sda_released_after_nack", bus.SDA_out, 1);
    bus_stop();
    expect_quiet = 1'b0;
    chk("busy_after_read_stop", busy, 0);
  endtask

  // Scoreboard monitor: strobes and bus observations are checked as they appear
  always @(negedge clock) begin
    if (wr_strobe) begin
      if (exp_wr_idx.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_strobe_unexpected: got index %0d expected no strobe", wr_index);
      end else begin
        int ei, ev;
        ei = exp_wr_idx.pop_front();
        ev = exp_wr_val.pop_front();
        chk("wr_index", int'(wr_index), ei);
        chk("wr_data", int'(regs_packed[8*ei +: 8]), ev);
      end
    end
    while (obs_bus.size() > 0) begin
      int o;
      exp_t e;
      o = obs_bus.pop_front();
      if (exp_bus.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_obs_unexpected: got 0x%0h expected nothing", o);
      end else begin
        e = exp_bus.pop_front();
        chk(e.kind == 0 ? "ack_bit" : "read_byte", o, e.val);
      end
    end
    if (expect_quiet && !reset) chk("sda_quiet_wrong_addr", bus.SDA_out, 1);
  end

  initial begin
    bq_t d;
    logic [8*NUM_REGS-1:0] zero_img;
    int kind, n;
    logic [6:0] a;
    logic [7:0] p;

    for (int j = 0; j < NUM_REGS; j++) mdl[j] = '0;
    zero_img = '0;
`ifdef I2C_RO_ID_EN
    zero_img[7:0] = IDV;
`endif
    clks(3);
    chk("reset_sda_out", bus.SDA_out, 1);
    chk("reset_busy", busy, 0);
    chk("reset_wr_strobe", wr_strobe, 0);
    chk("reset_regs", int'(regs_packed == zero_img), 1);
    reset = 1'b0;
    clks(5);

    // Directed: write, pointer+read, wrong address, wrap, range
    d = '{8'h11, 8'h22};
    xfer_write(ADDR, 8'h03, d);
    xfer_read(ADDR, 2, 1'b1, 8'h03);
    d = '{8'h5A, 8'hC3};
    xfer_write(7'h21, 8'h05, d);
    d = '{8'hAA, 8'hBB};
    xfer_write(ADDR, 8'h1F, d);
    xfer_read(ADDR, 2, 1'b1, 8'h1F);
    d = '{8'h55};
    xfer_write(ADDR, 8'h20, d);

    // Mid-byte abort: 5 data bits then STOP
    bus_start();
    send_byte({ADDR, 1'b0}, 1'b0);
    send_byte(8'h07, 1'b0);
    mdl_ptr = 7;
    for (int i = 0; i < 5; i++) put_bit(i[0]);
    bus_stop();
    chk("abort_busy", busy, 0);
    chk("abort_sda", bus.SDA_out, 1);
    d = '{8'h12, 8'h34};
    xfer_write(ADDR, 8'h07, d);

    // Randomised traffic
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 5) == 0) ? (ADDR ^ 7'($urandom_range(1, 127))) : ADDR;
      p = 8'($urandom_range(0, NUM_REGS + 6));
      n = $urandom_range(1, 4);
      if (kind < 5) begin
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
        xfer_write(a, p, d);
      end else begin
        xfer_read(a, n, (a == ADDR) && (kind != 9), p);
      end
    end

    // Reset while the target drives a 0 data bit during READ
    d = '{8'h12};
    xfer_write(ADDR, 8'h05, d);
    bus_start();
    send_byte({ADDR, 1'b0}, 1'b0);
    send_byte(8'h05, 1'b0);
    mdl_ptr = 5;
    bus_start();
    send_byte({ADDR, 1'b1}, 1'b0);
    clks(1);
    for (int i = 0; i < 50; i++) begin
      if (obs_bus.size() == 0 && exp_bus.size() == 0) break;
      clks(1);
    end
    chk("read_bit7_driven_low", bus.SDA_out, 0);
    chk("busy_mid_read", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_sda", bus.SDA_out, 1);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_regs", int'(regs_packed == zero_img), 1);
    scl_m = 1'b1; sda_m = 1'b1;
    for (int j = 0; j < NUM_REGS; j++) mdl[j] = '0;
    mdl_ptr = 0;
    clks(4);
    reset = 1'b0;
    clks(4);
    d = '{8'h9C};
    xfer_write(ADDR, 8'h02, d);
    xfer_read(ADDR, 1, 1'b1, 8'h02);

    for (int i = 0; i < 100; i++) begin
      if (exp_bus.size() == 0 && exp_wr_idx.size() == 0) break;
      clks(1);
    end
    chk("pending_bus_expectations", exp_bus.size(), 0);
    chk("pending_strobe_expectations", exp_wr_idx.size(), 0);
    for (int j = 0; j < NUM_REGS; j++)
      chk($sformatf("final_reg%0d", j), int'(regs_packed[8*j +: 8]), int'(mdl_rd(j)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
